// File: rtl/systolic_drain_pkg.sv
// rtl/systolic_drain_pkg.sv - shared constants, FSM state type and tile address helper for the drain
package systolic_pkg;

    localparam int DW        = 16;
    localparam int N         = 4;
    localparam int AW        = 8;
    localparam int MAX_TILES = 16;
    localparam int NN        = N * N;
    localparam int EW        = $clog2(NN);
    localparam int CW        = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TILE = 2'd1,
        WRITE     = 2'd2,
        FINISH    = 2'd3
    } drain_state_t;

    // First output-memory word of a tile; truncated to AW bits on purpose
    function automatic logic [AW-1:0] tile_base(input logic [CW-1:0] tile_idx);
        return AW'(32'(tile_idx) * NN);
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// rtl/systolic_drain_if.sv - tile handshake and output-memory write port of the drain stage
interface systolic_drain_if;
    import systolic_pkg::*;

    logic                 tile_valid;
    logic                 tile_ready;
    logic [NN*DW-1:0]     res_flat;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 wr_ready;

    // master: the drain itself
    modport master (
        input  tile_valid, res_flat, wr_ready,
        output tile_ready, wr_en, wr_addr, wr_data
    );

    // slave: array + output memory side
    modport slave (
        output tile_valid, res_flat, wr_ready,
        input  tile_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/drain_snapshot_buf.sv
// rtl/drain_snapshot_buf.sv - N*N x DW snapshot register file with parallel load and indexed read
module drain_snapshot_buf
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [NN*DW-1:0]  load_flat,
    input  logic [EW-1:0]     rd_idx,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [NN];

    // Whole tile is captured in a single cycle so the array is freed immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NN; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < NN; i++) mem[i] <= load_flat[i*DW +: DW];
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - drains 4x4 systolic tiles into output memory; DRAIN_RELU_EN enables a ReLU clamp on write data
module systolic_drain
    import systolic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CW-1:0]        num_tiles,
    systolic_drain_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        tiles_done
);

    drain_state_t   state;
    drain_state_t   state_nxt;
    logic [CW-1:0]  tile_cnt_lat;
    logic [CW-1:0]  tile_idx;
    logic [EW-1:0]  elem;
    logic [CW-1:0]  num_clamped;
    logic           capture;
    logic           accept;
    logic           last_elem;
    logic           last_tile;
    logic [DW-1:0]  snap_data;
    logic [DW-1:0]  write_word;
    logic           tile_ready_o;
    logic           wr_en_o;
    logic [AW-1:0]  wr_addr_o;
    logic [DW-1:0]  wr_data_o;

    assign num_clamped = (num_tiles == '0)              ? CW'(1) :
                         (num_tiles > CW'(MAX_TILES))   ? CW'(MAX_TILES) : num_tiles;
    assign capture     = (state == WAIT_TILE) && bus.tile_valid;
    assign accept      = (state == WRITE) && bus.wr_ready;
    assign last_elem   = (elem == EW'(NN - 1));
    assign last_tile   = ((tiles_done + CW'(1)) == tile_cnt_lat);

    drain_snapshot_buf u_snap (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .load_flat (bus.res_flat),
        .rd_idx    (elem),
        .rd_data   (snap_data)
    );

`ifdef DRAIN_RELU_EN
    assign write_word = snap_data[DW-1] ? '0 : snap_data;
`else
    assign write_word = snap_data;
`endif

    // State register; reset abandons any write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_TILE;
            WAIT_TILE: if (capture) state_nxt = WRITE;
            WRITE:     if (accept && last_elem) state_nxt = last_tile ? FINISH : WAIT_TILE;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Run length, tile and element counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt_lat <= '0;
            tile_idx     <= '0;
            tiles_done   <= '0;
            elem         <= '0;
        end else begin
            if (state == IDLE && start) begin
                tile_cnt_lat <= num_clamped;
                tile_idx     <= '0;
                tiles_done   <= '0;
                elem         <= '0;
            end
            if (capture) elem <= '0;
            if (accept) begin
                elem <= elem + EW'(1);
                if (last_elem) begin
                    tiles_done <= tiles_done + CW'(1);
                    tile_idx   <= tile_idx + CW'(1);
                end
            end
        end
    end

    // Moore outputs decoded from state; address/data forced to 0 outside WRITE
    always_comb begin
        tile_ready_o = 1'b0;
        wr_en_o      = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            WAIT_TILE: begin
                tile_ready_o = 1'b1;
                busy         = 1'b1;
            end
            WRITE: begin
                wr_en_o   = 1'b1;
                busy      = 1'b1;
                wr_addr_o = tile_base(tile_idx) + AW'(elem);
                wr_data_o = write_word;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.tile_ready = tile_ready_o;
    assign bus.wr_en      = wr_en_o;
    assign bus.wr_addr    = wr_addr_o;
    assign bus.wr_data    = wr_data_o;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - randomized self-checking bench for systolic_drain against a tile/address model
module tb_systolic_drain;
    import systolic_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_tiles;
    logic          busy;
    logic          done;
    logic [CW-1:0] tiles_done;

    systolic_drain_if bus();

    systolic_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tiles  (num_tiles),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .tiles_done (tiles_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] vals [MAX_TILES][NN];

    int obs_addr[$];
    int obs_data[$];
    int cyc      = 0;
    int last_acc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int wen_cyc  = 0;
    bit prev_stall = 0;
    int prev_a = 0;
    int prev_d = 0;
    bit abort    = 0;
    bit run_over = 0;

    task automatic check(input string tag, input int obs, input int req);
        n_checks++;
        if (obs == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] v);
`ifdef DRAIN_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [NN*DW-1:0] pack_tile(input int t);
        logic [NN*DW-1:0] r;
        for (int e = 0; e < NN; e++) r[e*DW +: DW] = vals[t][e];
        return r;
    endfunction

    task automatic rand_vals();
        for (int t = 0; t < MAX_TILES; t++)
            for (int e = 0; e < NN; e++) vals[t][e] = DW'($urandom);
    endtask

    // Write-port monitor: logs accepted writes and checks handshake invariants
    always @(negedge clk) begin
        #1;
        cyc++;
        if (bus.wr_en) begin
            wen_cyc++;
            check("tile_ready_low_in_write", int'(bus.tile_ready), 0);
            if (prev_stall) begin
                check("stall_hold_addr", int'(bus.wr_addr), prev_a);
                check("stall_hold_data", int'(bus.wr_data), prev_d);
            end
        end
        if (bus.wr_en && bus.wr_ready) begin
            obs_addr.push_back(int'(bus.wr_addr));
            obs_data.push_back(int'(bus.wr_data));
            last_acc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = bus.wr_en && !bus.wr_ready;
        prev_a     = int'(bus.wr_addr);
        prev_d     = int'(bus.wr_data);
    end

    // Array side: keeps tile_valid high with the next tile until it is taken
    task automatic drive_tiles(input int nt);
        for (int t = 0; t < nt; t++) begin
            int w;
            w = 0;
            bus.res_flat   = pack_tile(t);
            bus.tile_valid = 1'b1;
            while (!bus.tile_ready && !abort && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (abort) break;
            check("tile_accept", int'(bus.tile_ready), 1);
            if (!bus.tile_ready) break;
            @(posedge clk);
            #1;
        end
        bus.tile_valid = 1'b0;
    endtask

    task automatic wait_done(input int nt_eff);
        int w;
        w = 0;
        while (!done && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        check("tiles_done_final", int'(tiles_done), nt_eff);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("tiles_done_hold", int'(tiles_done), nt_eff);
    endtask

    // Memory side: mode 0 always ready, 1 random, 2 five-cycle stall at addr 7, 3 stray start during WRITE
    task automatic ready_proc(input int mode);
        bit once;
        once = 0;
        bus.wr_ready = 1'b1;
        while (!run_over) begin
            @(negedge clk);
            if (mode == 1) begin
                bus.wr_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && !once && bus.wr_en && bus.wr_addr == AW'(7)) begin
                once = 1;
                bus.wr_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_addr7", int'(bus.wr_addr), 7);
                    check("stall_data7", int'(bus.wr_data), int'(exp_data(vals[0][7])));
                end
                @(negedge clk);
                bus.wr_ready = 1'b1;
            end else if (mode == 3 && !once && bus.wr_en && bus.wr_addr == AW'(3)) begin
                once = 1;
                start = 1'b1;
                num_tiles = 5'd1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        bus.wr_ready = 1'b1;
    endtask

    task automatic do_run(input int nt_prog, input int mode);
        int nt_eff;
        nt_eff = (nt_prog == 0) ? 1 : ((nt_prog > MAX_TILES) ? MAX_TILES : nt_prog);
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_acc = -1;
        run_over = 0;
        @(negedge clk);
        num_tiles = CW'(nt_prog);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wen_cyc = 0;
        check("busy_after_start", int'(busy), 1);
        check("tiles_done_cleared", int'(tiles_done), 0);
        fork
            begin
                drive_tiles(nt_eff);
                wait_done(nt_eff);
                run_over = 1;
            end
            ready_proc(mode);
        join
        check("n_writes", obs_addr.size(), nt_eff * NN);
        for (int i = 0; i < obs_addr.size() && i < nt_eff * NN; i++) begin
            check("wr_addr_seq", obs_addr[i], i);
            check("wr_data_seq", obs_data[i], int'(exp_data(vals[i / NN][i % NN])));
        end
        check("done_after_last", done_cyc, last_acc + 1);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int w;
        int req0;
        rst = 1'b0;
        start = 1'b0;
        num_tiles = '0;
        bus.tile_valid = 1'b0;
        bus.res_flat = '0;
        bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tile_ready", int'(bus.tile_ready), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tiles_done", int'(tiles_done), 0);
        rst = 1'b1;

        // Single tile, r_ij = i*4+j+1
        for (int e = 0; e < NN; e++) vals[0][e] = DW'(e + 1);
        do_run(1, 0);
        check("t1_drain_cycles", wen_cyc, 16);

        // Three tiles, value = tile*100 + elem, random backpressure
        for (int t = 0; t < 3; t++)
            for (int e = 0; e < NN; e++) vals[t][e] = DW'(t * 100 + e);
        do_run(3, 1);
        if (obs_data.size() > 47) begin
            check("addr16_value", obs_data[16], 100);
            check("addr47_value", obs_data[47], 215);
        end

        // Five-cycle stall at elem 7
        rand_vals();
        do_run(1, 2);
        check("stall_drain_cycles", wen_cyc, 21);

        // Negative / positive values through the optional clamp
        rand_vals();
        vals[0][0] = 16'hFFF9;
        vals[0][1] = 16'd12;
        do_run(1, 0);
`ifdef DRAIN_RELU_EN
        req0 = 0;
`else
        req0 = 16'hFFF9;
`endif
        if (obs_data.size() > 1) begin
            check("neg_addr0", obs_data[0], req0);
            check("pos_addr1", obs_data[1], 12);
        end

        // Reset at elem 9 of tile 1
        rand_vals();
        abort = 0;
        @(negedge clk);
        num_tiles = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            drive_tiles(2);
            begin
                w = 0;
                while (!(bus.wr_en && bus.wr_addr == AW'(NN + 9)) && w < 3000) begin
                    @(negedge clk);
                    w++;
                end
                check("reached_t1_e9", int'(bus.wr_addr), NN + 9);
                rst = 1'b0;
                abort = 1;
                #1;
                check("midrst_wr_en", int'(bus.wr_en), 0);
                check("midrst_busy", int'(busy), 0);
                check("midrst_tile_ready", int'(bus.tile_ready), 0);
                check("midrst_wr_addr", int'(bus.wr_addr), 0);
            end
        join
        @(negedge clk);
        rst = 1'b1;
        abort = 0;
        check("midrst_tiles_done", int'(tiles_done), 0);
        rand_vals();
        do_run(1, 0);

        // Stray start during WRITE with tile_valid held high
        rand_vals();
        do_run(2, 3);

        // Clamp edges and random runs
        rand_vals();
        do_run(0, 1);
        rand_vals();
        do_run(31, 1);
        for (int r = 0; r < 3; r++) begin
            rand_vals();
            do_run($urandom_range(1, 20), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream stage of the 4x4 systolic array.
- Captures the 16 signed PE results of a finished tile in one cycle into a snapshot buffer.
- Serializes the buffer into the 256-entry output memory, one word per cycle, at address tile_idx*16 + row*4 + col.
- Counts tiles and raises done once the programmed number of tiles has been written; the top-level ap_done is driven from done.

Parameters:
- DW, 16, result/data width (signed)
- N, 4, array dimension (N*N results per tile)
- AW, 8, output memory address width
- MAX_TILES, 16, max tiles per run (MAX_TILES*N*N must equal 2**AW)

Ports:
- clk  in  1  clock
- rst  in  1  one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; begins a run, clears the tile counter
- num_tiles  in  5  tiles in this run, 1..MAX_TILES (sampled on start)
- tile_valid  in  1  array asserts when res_flat holds a finished tile
- tile_ready  out  1  drain can accept a tile
- res_flat  in  N*N*DW  r_ij at bits [(i*N+j)*DW +: DW]
- wr_en  out  1  output memory write strobe
- wr_addr  out  AW  output memory address
- wr_data  out  DW  output memory data
- wr_ready  in  1  memory accepts the write this cycle (stall when 0)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last word of the last tile is accepted
- tiles_done  out  5  tiles fully written in the current run

Behaviour:
- Reset (rst=0, async): state IDLE. tile_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, tiles_done=0. Snapshot buffer cleared to 0.
- FSM states: IDLE, WAIT_TILE, WRITE, FINISH.
- IDLE:
  - start=1 → latch num_tiles (0 is treated as 1; values >MAX_TILES are clamped to MAX_TILES).
  - Clear tile_idx and tiles_done; busy=1; go to WAIT_TILE.
- WAIT_TILE:
  - tile_ready=1.
  - On tile_valid & tile_ready, all N*N results are registered into the snapshot in that cycle.
  - Next cycle: WRITE with elem=0, and tile_ready=0.
- WRITE:
  - wr_en=1, wr_addr=tile_idx*N*N+elem, wr_data=snapshot[elem] (after optional clamp). elem is row-major: elem=i*N+j.
  - elem advances only when wr_en & wr_ready. While wr_ready=0, wr_en, addr and data are held stable.
  - After the write with elem=N*N-1 is accepted: tiles_done+1, tile_idx+1.
  - If tiles_done reaches the latched count → FINISH; otherwise → WAIT_TILE.
  - Minimum drain latency is N*N=16 cycles per tile from the capture cycle +1.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. tiles_done holds its value until the next start.
- start while busy: ignored.
- tile_valid outside WAIT_TILE: ignored, because tile_ready=0. The array must hold the tile until it is accepted.
- Address wrap: tile_idx*16+elem is computed in AW bits. With clamping it never exceeds 255, so no wrap occurs within a run.
- Reset mid-run: any in-flight write is abandoned, wr_en drops immediately (async), and the FSM returns to IDLE. Memory contents are not touched.
- Arithmetic: data is passed through unchanged (signed DW) unless RELU_EN is defined.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- Defined: wr_data = (snapshot[elem] < 0) ? 0 : snapshot[elem], e.g. -7 → 0 and 12 → 12. The clamp is combinational on the read path and adds no latency.
- Undefined: raw signed value written, e.g. -7 → 16'hFFF9.

Decomposition:
- Package systolic_pkg holds:
  - DW, N, AW, MAX_TILES constants
  - state enum {IDLE, WAIT_TILE, WRITE, FINISH}
  - function for tile base address (tile_idx*N*N)
- One sub-module: drain_snapshot_buf. It holds the N*N x DW register file with parallel load and indexed read of snapshot[elem], plus clear on reset.
- The FSM, counters and address generation stay in systolic_drain.

Test Plan:
- Reset, then start with num_tiles=1. Present res_flat with r_ij=i*4+j+1. Expected:
  - 16 consecutive writes, addr 0..15 with data 1..16.
  - done pulses 1 cycle after the write to addr 15.
  - tiles_done=1.
- num_tiles=3, each tile's values = tile*100 + elem. Expected:
  - addr 16 holds 100, addr 47 holds 215.
  - tile_ready is low during each WRITE phase.
  - done fires only after addr 47.
- wr_ready held 0 for 5 cycles at elem=7 of tile 0. Expected:
  - wr_addr=7 and wr_data stay constant for those cycles.
  - No skipped or duplicated addresses; total drain takes 21 cycles.
- num_tiles=1 with r_00=-7, r_01=12.
  - Without DRAIN_RELU_EN: addr0=16'hFFF9, addr1=12.
  - With it: addr0=0, addr1=12.
- Assert rst low at elem=9 of tile 1 in a 2-tile run. Expected:
  - wr_en=0 and busy=0 immediately.
  - After release, a fresh start with num_tiles=1 writes addr 0..15 correctly.
- Start pulse during WRITE, and tile_valid held high in WRITE. Expected:
  - Both are ignored; the run still completes with the originally latched num_tiles.
  - The next tile is captured only once state is WAIT_TILE.
